// File: rtl/filtr_feeder_pkg.sv
// Shared definitions for the filter feeder and related filter tops.
package filtr_feeder_pkg;

  // Sequencer states for the sample/done handshake.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_TRIG      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } feeder_state_t;

  // Width of the saturating event counters.
  localparam int STATS_W = 8;

  // Sample datapaths are one bit narrower than the filter word.
  function automatic int sample_width(input int data_size);
    return data_size - 1;
  endfunction

endpackage

// File: rtl/filtr_tick_gen.sv
// Free-running sample-period counter: tick is high for one clock every
// SAMPLE_DIV clocks (when the count sits at SAMPLE_DIV-1).
module filtr_tick_gen #(
  parameter int SAMPLE_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

  logic [CW-1:0] count;

  assign tick = (count == CW'(SAMPLE_DIV - 1));

  // Count 0..SAMPLE_DIV-1 and wrap; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset)    count <= '0;
    else if (tick) count <= '0;
    else           count <= count + 1'b1;
  end

endmodule

// File: rtl/filtr_feeder.sv
// Sample-rate sequencer feeding the notch filter: buffers one input sample,
// strobes f_sample every SAMPLE_DIV clocks, waits for f_done and presents
// f_result on a valid/ready output stream.
// Optional: define FEEDER_STATS_EN to build the underrun/overrun counters.
module filtr_feeder
  import filtr_feeder_pkg::*;
#(
  parameter int DATA_SIZE    = 25,
  parameter int SAMPLE_DIV   = 1000,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-2:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [DATA_SIZE-2:0] f_data,
  output logic                 f_sample,
  input  logic [DATA_SIZE-2:0] f_result,
  input  logic                 f_done,
  output logic [DATA_SIZE-2:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 err_timeout,
  output logic [STATS_W-1:0]   underrun_cnt,
  output logic [STATS_W-1:0]   overrun_cnt
);

  localparam int SW   = sample_width(DATA_SIZE);
  localparam int TO_W = $clog2(DONE_TIMEOUT + 1);

  feeder_state_t state, state_next;

  logic          tick;
  logic          buf_full;
  logic [SW-1:0] buf_data;
  logic [TO_W-1:0] to_cnt;

  logic load, take, underrun_ev, capture, timeout_ev, overrun_ev;

  filtr_tick_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign load       = s_valid & s_ready;
  assign overrun_ev = capture & m_valid & ~m_ready;
  assign f_sample   = (state == ST_TRIG);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state and per-cycle events; ticks outside IDLE are dropped.
  always_comb begin
    state_next  = state;
    take        = 1'b0;
    underrun_ev = 1'b0;
    capture     = 1'b0;
    timeout_ev  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (tick) begin
          state_next = ST_TRIG;
          if (buf_full) take        = 1'b1;
          else          underrun_ev = 1'b1;
        end
      end
      ST_TRIG: state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (f_done) begin
          capture    = 1'b1;
          state_next = ST_IDLE;
        end else if (to_cnt == TO_W'(DONE_TIMEOUT - 1)) begin
          timeout_ev = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Done-wait counter: zero outside WAIT_DONE, so every wait starts from 0.
  always_ff @(posedge clk) begin
    if (!reset || state != ST_WAIT_DONE) to_cnt <= '0;
    else                                 to_cnt <= to_cnt + 1'b1;
  end

  // One-entry input buffer; s_ready is registered so it reads 0 in reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_full <= 1'b0;
      buf_data <= '0;
      s_ready  <= 1'b0;
    end else begin
      if (load) begin
        buf_full <= 1'b1;
        buf_data <= s_data;
        s_ready  <= 1'b0;
      end else if (take) begin
        buf_full <= 1'b0;
        s_ready  <= 1'b1;
      end else begin
        s_ready  <= ~buf_full;
      end
    end
  end

  // Filter input register: updated only from a full buffer, else held.
  always_ff @(posedge clk) begin
    if (!reset)    f_data <= '0;
    else if (take) f_data <= buf_data;
  end

  // Output stream: capture overwrites, acceptance clears otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (capture) begin
      m_valid <= 1'b1;
      m_data  <= f_result;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!reset)          err_timeout <= 1'b0;
    else if (timeout_ev) err_timeout <= 1'b1;
  end

`ifdef FEEDER_STATS_EN
  logic [STATS_W-1:0] under_q, over_q;

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      under_q <= '0;
      over_q  <= '0;
    end else begin
      if (underrun_ev && under_q != '1) under_q <= under_q + 1'b1;
      if (overrun_ev  && over_q  != '1) over_q  <= over_q  + 1'b1;
    end
  end

  assign underrun_cnt = under_q;
  assign overrun_cnt  = over_q;
`else
  // Events still exist for the FSM; without stats nothing consumes them.
  logic unused_stats;
  assign unused_stats = underrun_ev ^ overrun_ev;
  assign underrun_cnt = '0;
  assign overrun_cnt  = '0;
`endif

endmodule
